dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 11 +
 rtl/dmem_bram_array.sv | 39 +++
 rtl/dmem_responder.sv | 127 ++++++++++++
 tb/tb_dmem_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding and the
// write-mode value that marks a load.
package dmem_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] WR_MODE_LOAD = 4'b0000;

endpackage

// File: rtl/dmem_bram_array.sv
// Single-port synchronous RAM with per-byte write enables and a registered,
// read-enabled output.
module dmem_bram_array #(
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 13,
  parameter     INIT_FILE  = ""
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [3:0]              wr_be,
  input  logic [4*BYTE_WIDTH-1:0] wdata,
  input  logic                    rd_en,
  output logic [4*BYTE_WIDTH-1:0] rdata
);

  localparam int DATA_W = 4 * BYTE_WIDTH;
  localparam int DEPTH  = 2 ** ADDR_WIDTH;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_be[i]) begin
        mem[addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Output register only loads when asked, so it doubles as the held response word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-masked stores, single-outstanding loads with a
// programmable latency. Define DMEM_RESPONDER_STATS_EN for load/store counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int BYTE_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 13,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = ""
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [3:0]              req_wr_mode,
  input  logic [4*BYTE_WIDTH-1:0] req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [4*BYTE_WIDTH-1:0] rsp_rdata
`ifdef DMEM_RESPONDER_STATS_EN
  ,
  output logic [31:0]             stat_loads,
  output logic [31:0]             stat_stores
`endif
);

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("dmem_responder: READ_LATENCY must be in 1..4");
  end

  localparam logic [2:0] LAT_M1 = 3'(READ_LATENCY - 1);

  logic [1:0]            state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  req_fire, is_load, is_store, rd_en;
  logic [3:0]            wr_be;

  assign req_fire = req_valid && req_ready;
  assign is_load  = req_fire && (req_wr_mode == WR_MODE_LOAD);
  assign is_store = req_fire && (req_wr_mode != WR_MODE_LOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (is_load) begin
      addr_q <= req_addr;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (is_load) begin
          if (READ_LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
  end

  // In IDLE the live request address feeds the RAM so a latency-1 load samples
  // at its own handshake edge; afterwards the captured address is used.
  assign ram_addr = (state_q == S_IDLE) ? req_addr : addr_q;
  assign rd_en    = (state_d == S_RESP) && (state_q != S_RESP);
  assign wr_be    = is_store ? req_wr_mode : 4'b0000;

  dmem_bram_array #(
    .BYTE_WIDTH (BYTE_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .addr  (ram_addr),
    .wr_be (wr_be),
    .wdata (req_wdata),
    .rd_en (rd_en),
    .rdata (rsp_rdata)
  );

`ifdef DMEM_RESPONDER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_loads  <= '0;
      stat_stores <= '0;
    end else begin
      if (is_load)  stat_loads  <= stat_loads + 32'd1;
      if (is_store) stat_stores <= stat_stores + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances at READ_LATENCY 1, 3 and 4
// sharing one clock, each driven independently.
module tb_dmem_responder;

  localparam int AW = 13;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic [2:0]    rst;
  logic [2:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [AW-1:0] req_addr    [3];
  logic [3:0]    req_wr_mode [3];
  logic [DW-1:0] req_wdata   [3];
  logic [DW-1:0] rsp_rdata   [3];
`ifdef DMEM_RESPONDER_STATS_EN
  logic [31:0]   stat_loads  [3];
  logic [31:0]   stat_stores [3];
`endif

  int n_vec = 0;
  int n_bad = 0;
  int n_ld [3];
  int n_st [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    dmem_responder #(
      .BYTE_WIDTH   (8),
      .ADDR_WIDTH   (AW),
      .READ_LATENCY (LAT),
      .INIT_FILE    ("")
    ) dut (
      .clk         (clk),
      .rst         (rst[g]),
      .req_valid   (req_valid[g]),
      .req_ready   (req_ready[g]),
      .req_addr    (req_addr[g]),
      .req_wr_mode (req_wr_mode[g]),
      .req_wdata   (req_wdata[g]),
      .rsp_valid   (rsp_valid[g]),
      .rsp_ready   (rsp_ready[g]),
      .rsp_rdata   (rsp_rdata[g])
`ifdef DMEM_RESPONDER_STATS_EN
      ,
      .stat_loads  (stat_loads[g]),
      .stat_stores (stat_stores[g])
`endif
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input int k, input logic [AW-1:0] a, input logic [3:0] m,
                       input logic [DW-1:0] d);
    req_valid[k]   = 1'b1;
    req_addr[k]    = a;
    req_wr_mode[k] = m;
    req_wdata[k]   = d;
    tick();
    req_valid[k] = 1'b0;
    n_st[k]++;
  endtask

  task automatic do_load(input int k, input logic [AW-1:0] a, input int lat,
                         input logic [DW-1:0] exp, input int hold);
    int edges;
    req_valid[k]   = 1'b1;
    req_addr[k]    = a;
    req_wr_mode[k] = 4'b0000;
    req_wdata[k]   = 32'h0BAD_0BAD;
    tick();
    req_valid[k] = 1'b0;
    n_ld[k]++;
    edges = 1;
    while (!rsp_valid[k] && edges < 12) begin
      check("wait_req_ready", {31'd0, req_ready[k]}, 32'd0);
      tick();
      edges++;
    end
    check("latency", edges, lat);
    check("rdata", rsp_rdata[k], exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_rsp_valid", {31'd0, rsp_valid[k]}, 32'd1);
      check("hold_req_ready", {31'd0, req_ready[k]}, 32'd0);
      check("hold_rdata", rsp_rdata[k], exp);
    end
    rsp_ready[k] = 1'b1;
    tick();
    rsp_ready[k] = 1'b0;
    check("post_rsp_valid", {31'd0, rsp_valid[k]}, 32'd0);
    check("post_req_ready", {31'd0, req_ready[k]}, 32'd1);
    check("post_rdata", rsp_rdata[k], exp);
  endtask

  initial begin
    int seen;
    rst       = 3'b111;
    req_valid = 3'b000;
    rsp_ready = 3'b000;
    for (int k = 0; k < 3; k++) begin
      req_addr[k]    = '0;
      req_wr_mode[k] = 4'b0000;
      req_wdata[k]   = '0;
      n_ld[k]        = 0;
      n_st[k]        = 0;
    end
    tick();
    tick();
    rst = 3'b000;
    tick();

    for (int k = 0; k < 3; k++) begin
      check("reset_req_ready", {31'd0, req_ready[k]}, 32'd1);
      check("reset_rsp_valid", {31'd0, rsp_valid[k]}, 32'd0);
      check("reset_rsp_rdata", rsp_rdata[k], 32'd0);
    end

    // Latency 1: read-after-write, byte-masked merge, back-to-back stores.
    store(0, 13'd5, 4'b1111, 32'hDEAD_BEEF);
    do_load(0, 13'd5, 1, 32'hDEAD_BEEF, 0);
    store(0, 13'd5, 4'b0100, 32'h00AA_0000);
    do_load(0, 13'd5, 1, 32'hDEAA_BEEF, 2);
    store(0, 13'd7, 4'b1111, 32'h1122_3344);
    store(0, 13'd8, 4'b1111, 32'h5566_7788);
    store(0, 13'd7, 4'b1001, 32'hAA00_00BB);
    do_load(0, 13'd8, 1, 32'h5566_7788, 0);
    do_load(0, 13'd7, 1, 32'hAA22_33BB, 0);

    rsp_ready[0] = 1'b1;
    tick();
    check("idle_rsp_ready_vld", {31'd0, rsp_valid[0]}, 32'd0);
    check("idle_rsp_ready_rdy", {31'd0, req_ready[0]}, 32'd1);
    rsp_ready[0] = 1'b0;

    // Latency 3 with a stalled consumer.
    store(1, 13'd5, 4'b1111, 32'hDEAD_BEEF);
    store(1, 13'd5, 4'b0100, 32'h00AA_0000);
    do_load(1, 13'd5, 3, 32'hDEAA_BEEF, 5);
    store(1, 13'd9, 4'b1111, 32'h0000_0000);
    store(1, 13'd9, 4'b0001, 32'hFFFF_FF5A);
    do_load(1, 13'd9, 3, 32'h0000_005A, 0);

    // Latency 4: reset while waiting drops the load, memory survives.
    store(2, 13'd5, 4'b1111, 32'hDEAD_BEEF);
    req_valid[2]   = 1'b1;
    req_addr[2]    = 13'd5;
    req_wr_mode[2] = 4'b0000;
    tick();
    req_valid[2] = 1'b0;
    tick();
    tick();
    rst[2] = 1'b1;
    #1;
    check("midrst_rsp_valid", {31'd0, rsp_valid[2]}, 32'd0);
    check("midrst_req_ready", {31'd0, req_ready[2]}, 32'd1);
    check("midrst_rsp_rdata", rsp_rdata[2], 32'd0);
    tick();
    rst[2]  = 1'b0;
    n_ld[2] = 0;
    n_st[2] = 0;
    seen    = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid[2]) seen = 1;
    end
    check("midrst_no_rsp", seen, 0);
    do_load(2, 13'd5, 4, 32'hDEAD_BEEF, 1);

`ifdef DMEM_RESPONDER_STATS_EN
    for (int k = 0; k < 3; k++) begin
      check("stat_stores", stat_stores[k], n_st[k]);
      check("stat_loads", stat_loads[k], n_ld[k]);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
